// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline definitions for the single-port memory arbiter.
// Holds the FSM state codes, the owner encoding and the default bus widths.
package mem_port_arbiter_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 16;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ST_IDLE   = 2'd0;
   localparam arb_state_t ST_ACCESS = 2'd1;
   localparam arb_state_t ST_WAIT   = 2'd2;
   localparam arb_state_t ST_RESP   = 2'd3;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data-stage and memory-side signals of the arbiter, bundled together.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;
   logic              if_stall;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_ack;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_stall;

   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, if_flush,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  mem_rdata,
      output if_ack, if_rdata, if_stall,
      output dm_ack, dm_rdata, dm_stall,
      output mem_rd, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, if_flush,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output mem_rdata,
      input  if_ack, if_rdata, if_stall,
      input  dm_ack, dm_rdata, dm_stall,
      input  mem_rd, mem_wr, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data stage,
// one access at a time, data first with a bounded wait for a pending fetch.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = 3
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus
);

   localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

   arb_state_t        state;
   logic              owner;
   logic              cmd_we;
   logic              flushed;
   logic [CNT_W-1:0]  starve_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;

   logic grant_dm;
   logic grant_if;
   logic flush_seen;

   // Data wins unless fetch has already waited through STARVE_MAX data grants.
   always_comb begin
      grant_dm = bus.dm_req && !(bus.if_req && (starve_cnt == CNT_MAX));
      grant_if = bus.if_req && !grant_dm;
   end

   assign flush_seen = flushed || (bus.if_flush && (owner == OWN_IF));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         owner      <= OWN_IF;
         cmd_we     <= 1'b0;
         flushed    <= 1'b0;
         starve_cnt <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               flushed <= 1'b0;
               if (!bus.if_req || grant_if)
                  starve_cnt <= '0;
               else if (grant_dm && (starve_cnt != CNT_MAX))
                  starve_cnt <= starve_cnt + CNT_W'(1);

               if (grant_dm) begin
                  owner   <= OWN_DM;
                  cmd_we  <= bus.dm_we;
                  addr_q  <= bus.dm_addr;
                  wdata_q <= bus.dm_wdata;
                  state   <= ST_ACCESS;
               end else if (grant_if) begin
                  owner  <= OWN_IF;
                  cmd_we <= 1'b0;
                  addr_q <= bus.if_addr;
                  state  <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (flush_seen)
                  flushed <= 1'b1;
               state <= cmd_we ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
               // A cancelled fetch still finishes on the memory but leaves if_rdata alone.
               if (owner == OWN_DM)
                  dm_rdata_q <= bus.mem_rdata;
               else if (!flush_seen)
                  if_rdata_q <= bus.mem_rdata;
               if (flush_seen)
                  flushed <= 1'b1;
               state <= ST_RESP;
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.mem_rd    = (state == ST_ACCESS) && !cmd_we;
   assign bus.mem_wr    = (state == ST_ACCESS) && cmd_we;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

   assign bus.if_ack   = (state == ST_RESP) && (owner == OWN_IF) && !flushed;
   assign bus.dm_ack   = (state == ST_RESP) && (owner == OWN_DM);
   assign bus.if_rdata = if_rdata_q;
   assign bus.dm_rdata = dm_rdata_q;
   assign bus.if_stall = bus.if_req && !bus.if_ack;
   assign bus.dm_stall = bus.dm_req && !bus.dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected acks,
// a negedge monitor pops and compares them; a simple memory model answers.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   typedef struct packed {
      logic        is_dm;
      logic        chk_data;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(16)) bus ();

   mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .STARVE_MAX(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t        exp_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          ack_count   = 0;
   int          wr_cycles   = 0;
   logic [15:0] mem [0:4095];

   // Memory model: write on the strobe edge, read data presented one cycle later.
   always @(posedge clk) begin
      if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic is_dm, input logic we, input logic [11:0] addr,
                                input logic [15:0] wdata, input logic expect_ack,
                                input logic [15:0] exp_data);
      if (expect_ack) exp_q.push_back(exp_t'{is_dm, (is_dm ? !we : 1'b1), exp_data});
      if (is_dm) begin
         bus.dm_req   = 1'b1;
         bus.dm_we    = we;
         bus.dm_addr  = addr;
         bus.dm_wdata = wdata;
      end else begin
         bus.if_req  = 1'b1;
         bus.if_addr = addr;
      end
   endtask

   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every ack must match the oldest outstanding expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.mem_wr) wr_cycles++;
      if (bus.if_ack || bus.dm_ack) begin
         ack_count++;
         checkOutput("dual_ack", {31'd0, bus.if_ack & bus.dm_ack}, 32'd0);
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_ack", {31'd0, bus.if_ack | bus.dm_ack}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("ack_owner", {31'd0, bus.dm_ack}, {31'd0, e.is_dm});
            if (e.chk_data)
               checkOutput(e.is_dm ? "dm_rdata" : "if_rdata",
                           {16'd0, (e.is_dm ? bus.dm_rdata : bus.if_rdata)}, {16'd0, e.data});
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: got running, expected finished");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      int budget;
      int base;
      int wr0;

      bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
      mem[12'h010] = 16'hA5C3;
      mem[12'h030] = 16'hBEEF;

      // Reset values
      repeat (2) nextCycle;
      @(negedge clk);
      checkOutput("rst_if_ack",    {31'd0, bus.if_ack}, 0);
      checkOutput("rst_dm_ack",    {31'd0, bus.dm_ack}, 0);
      checkOutput("rst_mem_rd",    {31'd0, bus.mem_rd}, 0);
      checkOutput("rst_mem_wr",    {31'd0, bus.mem_wr}, 0);
      checkOutput("rst_mem_addr",  {20'd0, bus.mem_addr}, 0);
      checkOutput("rst_mem_wdata", {16'd0, bus.mem_wdata}, 0);
      checkOutput("rst_if_rdata",  {16'd0, bus.if_rdata}, 0);
      checkOutput("rst_dm_rdata",  {16'd0, bus.dm_rdata}, 0);
      nextCycle;
      rst = 1'b0;
      nextCycle;

      // Lone fetch read
      $display("[TB] lone fetch read");
      applyStimulus(1'b0, 1'b0, 12'h010, 16'h0, 1'b1, 16'hA5C3);
      @(negedge clk); checkOutput("f_stall_c0", {31'd0, bus.if_stall}, 1);
      nextCycle;
      @(negedge clk); checkOutput("f_stall_c1", {31'd0, bus.if_stall}, 1);
      checkOutput("f_mem_rd_c1", {31'd0, bus.mem_rd}, 1);
      checkOutput("f_mem_addr_c1", {20'd0, bus.mem_addr}, 32'h010);
      nextCycle;
      @(negedge clk); checkOutput("f_stall_c2", {31'd0, bus.if_stall}, 1);
      checkOutput("f_mem_rd_c2", {31'd0, bus.mem_rd}, 0);
      nextCycle;
      @(negedge clk); checkOutput("f_ack_c3", {31'd0, bus.if_ack}, 1);
      checkOutput("f_stall_c3", {31'd0, bus.if_stall}, 0);
      nextCycle;
      bus.if_req = 1'b0;
      nextCycle;

      // Data write then read back
      $display("[TB] data write and read");
      wr0 = wr_cycles;
      applyStimulus(1'b1, 1'b1, 12'h020, 16'h1234, 1'b1, 16'h0);
      nextCycle;
      @(negedge clk); checkOutput("w_mem_wr_c1", {31'd0, bus.mem_wr}, 1);
      checkOutput("w_mem_addr_c1", {20'd0, bus.mem_addr}, 32'h020);
      checkOutput("w_mem_wdata_c1", {16'd0, bus.mem_wdata}, 32'h1234);
      nextCycle;
      @(negedge clk); checkOutput("w_ack_c2", {31'd0, bus.dm_ack}, 1);
      checkOutput("w_mem_wr_c2", {31'd0, bus.mem_wr}, 0);
      nextCycle;
      checkOutput("w_pulse_count", wr_cycles - wr0, 1);
      applyStimulus(1'b1, 1'b0, 12'h020, 16'h0, 1'b1, 16'h1234);
      repeat (3) nextCycle;
      @(negedge clk); checkOutput("r_ack_c3", {31'd0, bus.dm_ack}, 1);
      nextCycle;
      bus.dm_req = 1'b0;
      nextCycle;

      // Both requesting continuously: D,D,D,F,D,D,D,F
      $display("[TB] starvation bound");
      base = ack_count;
      for (int k = 0; k < 8; k++)
         exp_q.push_back((k % 4 == 3) ? exp_t'{1'b0, 1'b1, 16'hA5C3} : exp_t'{1'b1, 1'b1, 16'h1234});
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 12'h020;
      bus.if_req = 1'b1; bus.if_addr = 12'h010;
      budget = 200;
      while ((ack_count < base + 8) && (budget > 0)) begin
         @(posedge clk);
         budget--;
      end
      if (ack_count < base + 8) checkOutput("starve_timeout", ack_count - base, 8);
      #1;
      bus.dm_req = 1'b0; bus.if_req = 1'b0;
      nextCycle;

      // Flush during WAIT of a fetch
      $display("[TB] fetch flush");
      applyStimulus(1'b0, 1'b0, 12'h030, 16'h0, 1'b0, 16'h0);
      nextCycle;
      nextCycle;
      bus.if_flush = 1'b1;
      nextCycle;
      bus.if_flush = 1'b0; bus.if_req = 1'b0;
      @(negedge clk); checkOutput("flush_no_ack", {31'd0, bus.if_ack}, 0);
      nextCycle;
      applyStimulus(1'b1, 1'b1, 12'h050, 16'h7777, 1'b1, 16'h0);
      @(negedge clk); checkOutput("flush_rdata_kept", {16'd0, bus.if_rdata}, 32'hA5C3);
      nextCycle;
      @(negedge clk); checkOutput("flush_idle_c4", {31'd0, bus.mem_wr}, 1);
      nextCycle;
      @(negedge clk); checkOutput("flush_next_ack", {31'd0, bus.dm_ack}, 1);
      nextCycle;
      bus.dm_req = 1'b0;
      nextCycle;

      // Reset during WAIT of a data read
      $display("[TB] reset mid-read");
      applyStimulus(1'b1, 1'b0, 12'h020, 16'h0, 1'b0, 16'h0);
      nextCycle;
      nextCycle;
      rst = 1'b1; bus.dm_req = 1'b0;
      nextCycle;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("mrst_dm_ack",    {31'd0, bus.dm_ack}, 0);
      checkOutput("mrst_mem_rd",    {31'd0, bus.mem_rd}, 0);
      checkOutput("mrst_mem_wr",    {31'd0, bus.mem_wr}, 0);
      checkOutput("mrst_mem_addr",  {20'd0, bus.mem_addr}, 0);
      checkOutput("mrst_mem_wdata", {16'd0, bus.mem_wdata}, 0);
      checkOutput("mrst_if_rdata",  {16'd0, bus.if_rdata}, 0);
      checkOutput("mrst_dm_rdata",  {16'd0, bus.dm_rdata}, 0);
      repeat (4) nextCycle;

      // Data drops its request on the ack edge, fetch takes over
      $display("[TB] handover on ack edge");
      wr0 = wr_cycles;
      applyStimulus(1'b1, 1'b1, 12'h040, 16'h5A5A, 1'b1, 16'h0);
      nextCycle;
      nextCycle;
      @(negedge clk); checkOutput("ho_dm_ack", {31'd0, bus.dm_ack}, 1);
      nextCycle;
      bus.dm_req = 1'b0;
      applyStimulus(1'b0, 1'b0, 12'h010, 16'h0, 1'b1, 16'hA5C3);
      @(negedge clk); checkOutput("ho_idle_rd", {31'd0, bus.mem_rd}, 0);
      checkOutput("ho_idle_wr", {31'd0, bus.mem_wr}, 0);
      nextCycle;
      @(negedge clk); checkOutput("ho_fetch_rd", {31'd0, bus.mem_rd}, 1);
      checkOutput("ho_fetch_addr", {20'd0, bus.mem_addr}, 32'h010);
      nextCycle;
      nextCycle;
      @(negedge clk); checkOutput("ho_if_ack", {31'd0, bus.if_ack}, 1);
      nextCycle;
      bus.if_req = 1'b0;
      checkOutput("ho_single_write", wr_cycles - wr0, 1);

      repeat (3) nextCycle;
      checkOutput("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares one single-port 16-bit memory between the instruction-fetch requester and the data-memory stage of the 5-stage pipeline. Requests are served one at a time through a small state machine. The data stage has priority, with a bounded-starvation guarantee for fetch. Per-requester stall outputs let the pipeline freeze its buffer registers while an access is outstanding.

## Interface
- ADDR_W, 12, memory address width
- DATA_W, 16, memory word width
- STARVE_MAX, 3, consecutive data grants allowed while fetch is pending before fetch must win (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request; held until if_ack
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_flush  in  1  cancel the in-flight fetch (branch/reset of PC)
- if_ack  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched instruction word
- if_stall  out  1  if_req & ~if_ack (combinational)
- dm_req  in  1  data request; held until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_ack  out  1  one-cycle pulse; dm_rdata valid on reads
- dm_rdata  out  DATA_W  read data
- dm_stall  out  1  dm_req & ~dm_ack (combinational)
- mem_rd, mem_wr  out  1 each  memory strobes
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  valid in the cycle after mem_rd is high

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: requests are sampled only here. The winner is registered at the clock edge, along with owner, addr, we and wdata, and the FSM moves to ACCESS. With no request it stays in IDLE.
- Arbitration at the IDLE edge:
  - Data wins by default.
  - Fetch wins if only fetch requests.
  - Fetch also wins if both request and starve_cnt == STARVE_MAX.
- starve_cnt, width clog2(STARVE_MAX+1):
  - increments on each data grant while if_req is high;
  - clears on a fetch grant, and in any IDLE cycle with if_req low;
  - saturates at STARVE_MAX.
- ACCESS: mem_rd or mem_wr is driven high for exactly this cycle from the registered command. A write goes to RESP. A read goes to WAIT.
- WAIT: mem_rdata is captured into the owner's rdata register at the end of the cycle. The FSM then goes to RESP.
- RESP: the owner's ack is high for exactly this cycle. The FSM always returns to IDLE, so requests seen at the edge ending RESP are ignored. This lets the requester drop or replace its request on that edge without a stale re-grant.
- if_flush:
  - Seen high during ACCESS or WAIT of a fetch: the access completes on the memory but if_ack is suppressed in RESP, and if_rdata is not updated.
  - Seen high in IDLE: it has no effect on the grant decision.
- Only one of mem_rd or mem_wr is ever high. Both are 0 outside ACCESS.
- mem_addr and mem_wdata hold their last registered value when idle.

## Timing
- Reset (synchronous): FSM=IDLE, starve_cnt=0. These outputs go to 0: if_ack, dm_ack, mem_rd, mem_wr, mem_addr, mem_wdata, if_rdata, dm_rdata.
- Reset mid-operation: the in-flight access is abandoned and no ack is issued. A write already strobed in ACCESS is not undone.
- Cycle numbering: the request is high in cycle 0 with FSM in IDLE.
  - Read: ACCESS in cycle 1, WAIT in cycle 2, ack with data in cycle 3.
  - Write: ACCESS in cycle 1, ack in cycle 2.
  - The next grant is taken at the end of cycle 4 (read) or cycle 3 (write).
- A request arriving while busy waits for the next IDLE. Its stall output stays high throughout.
- Simultaneous requests on the same IDLE edge are resolved only by the arbitration rule. The loser keeps its request and is served next.

## Structure
- Shared pipeline package holds:
  - the state enum (IDLE/ACCESS/WAIT/RESP);
  - the owner encoding (OWN_IF=0, OWN_DM=1);
  - default ADDR_W/DATA_W constants.
- Single module. No sub-module is warranted; the fairness counter and FSM are small and tightly coupled.

## Test plan
- Lone fetch read, if_addr=0x010, mem word 0xA5C3: if_ack in cycle 3 with if_rdata=0xA5C3; if_stall high in cycles 0–2.
- Lone data write to 0x020 with 0x1234, then a data read of 0x020: dm_ack in cycle 2, then a read ack returning 0x1234; mem_wr high for exactly one cycle.
- Both request every IDLE, STARVE_MAX=3: grant order D,D,D,F,D,D,D,F; the fetch wait never exceeds 3 data grants.
- if_flush pulsed during WAIT of a fetch: no if_ack, if_rdata unchanged, FSM back in IDLE 2 cycles later.
- rst asserted in WAIT of a data read: next cycle is IDLE with all outputs 0, and no dm_ack ever appears for that read.
- Requester drops dm_req on the ack edge and raises if_req: no duplicate data access; fetch is granted at the following IDLE edge.
